// File: rtl/spill_register.sv
// Purpose: two-entry valid/ready spill register that registers valid, ready and data in both directions.
// Latency: a beat accepted in cycle n is presented downstream in cycle n+1 (zero when Bypass=1).
// Backpressure: holds up to two beats; ready_o drops only when both slots are full.
//
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   valid_i, ready_o, data_i  - upstream handshake and payload
//   valid_o, ready_i, data_o  - downstream handshake and payload
//   T                         - payload type, Bypass - 1 = plain wires
module spill_register #(
  parameter type T      = logic,
  parameter bit  Bypass = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic valid_i,
  output logic ready_o,
  input  T     data_i,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  if (Bypass) begin : gen_bypass
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;

    // Clock and reset have no function in the feed-through build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_i;
  end else begin : gen_spill
    // Slot A takes every accepted beat; slot B catches A's beat when the
    // downstream stalls, so the upstream ready never depends on ready_i.
    logic a_full_q, b_full_q;
    T     a_data_q, b_data_q;

    logic a_fill, a_drain, b_fill, b_drain;

    assign a_fill  = valid_i & ready_o;
    assign a_drain = a_full_q & ~b_full_q;
    assign b_fill  = a_drain & ~ready_i;
    assign b_drain = b_full_q & ready_i;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        a_full_q <= 1'b0;
        a_data_q <= T'('0);
      end else begin
        if (a_fill) begin
          a_data_q <= data_i;
        end
        a_full_q <= a_fill | (a_full_q & ~a_drain);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        b_full_q <= 1'b0;
        b_data_q <= T'('0);
      end else begin
        if (b_fill) begin
          b_data_q <= a_data_q;
        end
        b_full_q <= b_fill | (b_full_q & ~b_drain);
      end
    end

    // B always holds the older beat when both are full, so it goes first.
    assign valid_o = a_full_q | b_full_q;
    assign ready_o = ~a_full_q | ~b_full_q;
    assign data_o  = b_full_q ? b_data_q : a_data_q;
  end

endmodule

// File: tb/tb_spill_register.sv
// Purpose: directed self-checking bench for spill_register (registered and bypass builds).
// Latency: checks one-cycle latency for the registered build, zero for bypass.
// Backpressure: exercises two-beat holding, stall of a third beat and in-order drain.
module tb_spill_register;

  logic       clk;
  logic       rst;

  logic       valid_i, ready_i, valid_o, ready_o;
  logic [7:0] data_i, data_o;

  logic       bp_valid_i, bp_ready_i, bp_valid_o, bp_ready_o;
  logic [7:0] bp_data_i, bp_data_o;

  int tests_run;
  int tests_failed;

  spill_register #(.T(logic [7:0]), .Bypass(1'b0)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o)
  );

  spill_register #(.T(logic [7:0]), .Bypass(1'b1)) dut_bp (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (bp_valid_i),
    .ready_o (bp_ready_o),
    .data_i  (bp_data_i),
    .valid_o (bp_valid_o),
    .ready_i (bp_ready_i),
    .data_o  (bp_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle; outputs are then stable for checking.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid_o: got %b expected 0", valid_o);
    end
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_o: got %b expected 1", ready_o);
    end
    tests_run++;
    if (data_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data_o: got %h expected 00", data_o);
    end
  endtask

  task automatic test_single_beat();
    ready_i = 1'b1;
    valid_i = 1'b1;
    data_i = 8'hA5;
    tick();
    valid_i = 1'b0;
    data_i = 8'h00;
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_out: got valid=%b data=%h expected valid=1 data=a5", valid_o, data_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_gone: got valid=%b expected 0", valid_o);
    end
  endtask

  task automatic test_streaming();
    ready_i = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      valid_i = 1'b1;
      data_i = 8'(i);
      tests_run++;
      if (ready_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL stream_ready beat %0d: got %b expected 1", i, ready_o);
      end
      tick();
      tests_run++;
      if (valid_o !== 1'b1 || data_o !== 8'(i)) begin
        tests_failed++;
        $display("FAIL stream_out beat %0d: got valid=%b data=%h expected valid=1 data=%h",
                 i, valid_o, data_o, 8'(i));
      end
    end
    valid_i = 1'b0;
    tick();
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_end: got valid=%b expected 0", valid_o);
    end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = 8'h11;
    tests_run++;
    if (ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_accept_11: ready got %b expected 1", ready_o);
    end
    tick();
    data_i = 8'h22;
    tests_run++;
    if (ready_o !== 1'b1 || valid_o !== 1'b1 || data_o !== 8'h11) begin
      tests_failed++;
      $display("FAIL bp_accept_22: got ready=%b valid=%b data=%h expected 1 1 11",
               ready_o, valid_o, data_o);
    end
    tick();
    data_i = 8'h33;
    tests_run++;
    if (ready_o !== 1'b0 || data_o !== 8'h11) begin
      tests_failed++;
      $display("FAIL bp_full: got ready=%b data=%h expected ready=0 data=11", ready_o, data_o);
    end
    // Offer 0x33 for two stalled cycles; nothing may move.
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1 || data_o !== 8'h11) begin
        tests_failed++;
        $display("FAIL bp_stall cycle %0d: got ready=%b valid=%b data=%h expected 0 1 11",
                 c, ready_o, valid_o, data_o);
      end
    end
    // Release: 0x11 transfers now; 0x33 is accepted once ready_o reopens.
    ready_i = 1'b1;
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 8'h11) begin
      tests_failed++;
      $display("FAIL bp_drain_1: got valid=%b data=%h expected 1 11", valid_o, data_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 8'h22 || ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_drain_2: got valid=%b data=%h ready=%b expected 1 22 1",
               valid_o, data_o, ready_o);
    end
    tick();
    valid_i = 1'b0;
    tests_run++;
    if (valid_o !== 1'b1 || data_o !== 8'h33) begin
      tests_failed++;
      $display("FAIL bp_drain_3: got valid=%b data=%h expected 1 33", valid_o, data_o);
    end
    tick();
    tests_run++;
    if (valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: got valid=%b expected 0", valid_o);
    end
  endtask

  task automatic test_mid_reset();
    ready_i = 1'b0;
    valid_i = 1'b1;
    data_i = 8'h44;
    tick();
    data_i = 8'h55;
    tick();
    valid_i = 1'b0;
    tests_run++;
    if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_reset_full: got ready=%b valid=%b expected 0 1", ready_o, valid_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || data_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset_out: got valid=%b ready=%b data=%h expected 0 1 00",
               valid_o, ready_o, data_o);
    end
    ready_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (valid_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL mid_reset_leak cycle %0d: got valid=%b data=%h expected valid 0",
                 c, valid_o, data_o);
      end
    end
  endtask

  task automatic test_bypass();
    for (int i = 0; i < 20; i++) begin
      bp_valid_i = 1'($urandom_range(0, 1));
      bp_ready_i = 1'($urandom_range(0, 1));
      bp_data_i  = 8'($urandom_range(0, 255));
      #1;
      tests_run++;
      if (bp_valid_o !== bp_valid_i || bp_ready_o !== bp_ready_i || bp_data_o !== bp_data_i) begin
        tests_failed++;
        $display("FAIL bypass vec %0d: got v=%b r=%b d=%h expected v=%b r=%b d=%h",
                 i, bp_valid_o, bp_ready_o, bp_data_o, bp_valid_i, bp_ready_i, bp_data_i);
      end
      #3;
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i = 8'h00;
    bp_valid_i = 1'b0;
    bp_ready_i = 1'b0;
    bp_data_i = 8'h00;

    test_reset();
    test_single_beat();
    test_streaming();
    test_backpressure();
    test_mid_reset();
    test_bypass();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
